// File: rtl/bram_sdp_banked.sv
// Banked simple-dual-port block RAM: port A writes, port B reads with 1- or 2-cycle latency.
// When CLEAR_ON_RESET is set, every bank is swept to zero after reset before the ports open.
module bram_sdp_banked #(
    parameter int DW             = 16,
    parameter int DEPTH          = 1024,
    parameter int BANKS          = 2,
    parameter int RD_LAT         = 1,
    parameter int RDW_NEW        = 0,
    parameter int CLEAR_ON_RESET = 1,
    localparam int AW = (DEPTH <= 1) ? 1 : $clog2(DEPTH),
    localparam int BW = (BANKS <= 1) ? 1 : $clog2(BANKS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_en,
    input  logic                 a_we,
    input  logic [BW-1:0]        a_bank,
    input  logic [AW-1:0]        a_addr,
    input  logic signed [DW-1:0] a_din,
    input  logic                 b_en,
    input  logic [BW-1:0]        b_bank,
    input  logic [AW-1:0]        b_addr,
    output logic signed [DW-1:0] b_dout,
    output logic                 b_valid,
    output logic                 busy
);

    typedef enum logic {CLEAR, READY} state_t;

    localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
    localparam logic [BW:0]   BANKS_W   = (BW+1)'(BANKS);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] clr_addr_q, clr_addr_d;

    logic             a_ok, b_ok, wr_acc, rd_acc, rd_hit, byp;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic [BANKS-1:0] bank_we, bank_re;
    logic [BANKS-1:0][DW-1:0] bank_rd;

    logic          s1_valid_q, s1_valid_d, s1_oor_q, s1_oor_d;
    logic          s1_byp_q, s1_byp_d, have_q, have_d;
    logic [BW-1:0] s1_bank_q, s1_bank_d;
    logic [DW-1:0] s1_byp_data_q, s1_byp_data_d;
    logic [DW-1:0] s1_data;
    logic          s2_valid_q, s2_valid_d;
    logic [DW-1:0] s2_dout_q, s2_dout_d;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            CLEAR: begin
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == LAST_ADDR) begin
                    state_d    = READY;
                    clr_addr_d = '0;
                end
            end
            READY: state_d = READY;
            default: state_d = READY;
        endcase
    end

    always_comb begin
        busy = (state_q == CLEAR);
    end

    // During CLEAR every bank is written at clr_addr; the ports are locked out.
    always_comb begin
        a_ok    = ({1'b0, a_addr} < DEPTH_W) && ({1'b0, a_bank} < BANKS_W);
        b_ok    = ({1'b0, b_addr} < DEPTH_W) && ({1'b0, b_bank} < BANKS_W);
        wr_acc  = a_en && a_we && !busy && a_ok;
        rd_acc  = b_en && !busy;
        rd_hit  = rd_acc && b_ok;
        byp     = (RDW_NEW != 0) && wr_acc && rd_hit &&
                  (a_bank == b_bank) && (a_addr == b_addr);
        wr_addr = busy ? clr_addr_q : a_addr;
        wr_data = busy ? '0 : a_din;
        for (int unsigned k = 0; k < BANKS; k++) begin
            bank_we[k] = busy || (wr_acc && (a_bank == BW'(k)));
            bank_re[k] = rd_hit && (b_bank == BW'(k));
        end
    end

    // Storage stays reset-free and read-first so each bank maps onto one block RAM.
    for (genvar k = 0; k < BANKS; k++) begin : g_bank
        logic [DW-1:0] mem [DEPTH];
        logic [DW-1:0] rd_q;
        always_ff @(posedge clk) begin
            if (bank_we[k]) mem[wr_addr] <= wr_data;
            if (bank_re[k]) rd_q <= mem[b_addr];
        end
        assign bank_rd[k] = rd_q;
    end

    always_comb begin
        s1_valid_d    = rd_acc;
        s1_oor_d      = rd_acc ? !b_ok : s1_oor_q;
        s1_byp_d      = rd_acc ? byp : s1_byp_q;
        s1_bank_d     = rd_acc ? b_bank : s1_bank_q;
        s1_byp_data_d = rd_acc ? a_din : s1_byp_data_q;
        have_d        = have_q || rd_acc;

        // Sideband regs only move on an accepted read, so the result holds between reads.
        s1_data = '0;
        if (have_q && !s1_oor_q) begin
            s1_data = s1_byp_q ? s1_byp_data_q : bank_rd[s1_bank_q];
        end

        s2_valid_d = s1_valid_q;
        s2_dout_d  = s1_valid_q ? s1_data : s2_dout_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if (CLEAR_ON_RESET != 0) state_q <= CLEAR;
            else                     state_q <= READY;
            clr_addr_q    <= '0;
            s1_valid_q    <= 1'b0;
            s1_oor_q      <= 1'b0;
            s1_byp_q      <= 1'b0;
            s1_bank_q     <= '0;
            s1_byp_data_q <= '0;
            have_q        <= 1'b0;
            s2_valid_q    <= 1'b0;
            s2_dout_q     <= '0;
        end else begin
            state_q       <= state_d;
            clr_addr_q    <= clr_addr_d;
            s1_valid_q    <= s1_valid_d;
            s1_oor_q      <= s1_oor_d;
            s1_byp_q      <= s1_byp_d;
            s1_bank_q     <= s1_bank_d;
            s1_byp_data_q <= s1_byp_data_d;
            have_q        <= have_d;
            s2_valid_q    <= s2_valid_d;
            s2_dout_q     <= s2_dout_d;
        end
    end

    always_comb begin
        b_valid = (RD_LAT == 2) ? s2_valid_q : s1_valid_q;
        b_dout  = (RD_LAT == 2) ? s2_dout_q : s1_data;
    end

endmodule

// File: tb/tb_bram_sdp_banked.sv
// Self-checking bench: three configurations of bram_sdp_banked checked against a latency-aware scoreboard.
module tb_bram_sdp_banked;

    logic clk;
    logic rst;

    // u0 (RD_LAT=1, old-data) and u1 (RD_LAT=2, new-data) share one stimulus set.
    logic               a_en, a_we, a_bank, b_en, b_bank;
    logic [3:0]         a_addr, b_addr;
    logic signed [15:0] a_din;
    logic signed [15:0] d0, d1, d2;
    logic               v0, v1, v2, busy0, busy1, busy2;

    // u2: DEPTH=12, BANKS=3 for out-of-range handling.
    logic               c_a_en, c_a_we, c_b_en;
    logic [1:0]         c_a_bank, c_b_bank;
    logic [3:0]         c_a_addr, c_b_addr;
    logic signed [15:0] c_a_din;

    bram_sdp_banked #(.DW(16), .DEPTH(16), .BANKS(2), .RD_LAT(1), .RDW_NEW(0), .CLEAR_ON_RESET(1)) u0 (
        .clk(clk), .rst(rst), .a_en(a_en), .a_we(a_we), .a_bank(a_bank), .a_addr(a_addr),
        .a_din(a_din), .b_en(b_en), .b_bank(b_bank), .b_addr(b_addr),
        .b_dout(d0), .b_valid(v0), .busy(busy0));

    bram_sdp_banked #(.DW(16), .DEPTH(16), .BANKS(2), .RD_LAT(2), .RDW_NEW(1), .CLEAR_ON_RESET(1)) u1 (
        .clk(clk), .rst(rst), .a_en(a_en), .a_we(a_we), .a_bank(a_bank), .a_addr(a_addr),
        .a_din(a_din), .b_en(b_en), .b_bank(b_bank), .b_addr(b_addr),
        .b_dout(d1), .b_valid(v1), .busy(busy1));

    bram_sdp_banked #(.DW(16), .DEPTH(12), .BANKS(3), .RD_LAT(1), .RDW_NEW(0), .CLEAR_ON_RESET(1)) u2 (
        .clk(clk), .rst(rst), .a_en(c_a_en), .a_we(c_a_we), .a_bank(c_a_bank), .a_addr(c_a_addr),
        .a_din(c_a_din), .b_en(c_b_en), .b_bank(c_b_bank), .b_addr(c_b_addr),
        .b_dout(d2), .b_valid(v2), .busy(busy2));

    typedef struct {
        logic               a_en;
        logic               a_we;
        logic [1:0]         a_bank;
        logic [3:0]         a_addr;
        logic signed [15:0] a_din;
        logic               b_en;
        logic [1:0]         b_bank;
        logic [3:0]         b_addr;
        logic signed [15:0] exp_old;
        logic signed [15:0] exp_new;
    } vec_t;

    typedef struct {
        int                 due;
        logic signed [15:0] data;
    } sb_t;

    vec_t               tab[16];
    vec_t               tab2[12];
    sb_t                sbq[3][$];
    logic signed [15:0] last_exp[3];
    int                 cyc;
    int                 n_vec;
    int                 n_bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic vec_t mk(input int ae, input int aw, input int ab, input int aa, input int ad,
                                input int be, input int bb, input int ba, input int eo, input int en);
        vec_t v;
        v.a_en    = ae[0];
        v.a_we    = aw[0];
        v.a_bank  = ab[1:0];
        v.a_addr  = aa[3:0];
        v.a_din   = ad[15:0];
        v.b_en    = be[0];
        v.b_bank  = bb[1:0];
        v.b_addr  = ba[3:0];
        v.exp_old = eo[15:0];
        v.exp_new = en[15:0];
        return v;
    endfunction

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, want %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic check_out(input int i, input logic v, input logic signed [15:0] d);
        if (sbq[i].size() > 0 && sbq[i][0].due == cyc) begin
            chk($sformatf("u%0d b_valid", i), v, 1);
            chk($sformatf("u%0d b_dout", i), d, sbq[i][0].data);
            last_exp[i] = sbq[i][0].data;
            void'(sbq[i].pop_front());
        end else begin
            chk($sformatf("u%0d b_valid idle", i), v, 0);
            chk($sformatf("u%0d b_dout hold", i), d, last_exp[i]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        check_out(0, v0, d0);
        check_out(1, v1, d1);
        check_out(2, v2, d2);
    endtask

    task automatic push(input int i, input int lat, input logic signed [15:0] data);
        sb_t e;
        e.due  = cyc + lat;
        e.data = data;
        sbq[i].push_back(e);
    endtask

    task automatic flush();
        for (int i = 0; i < 3; i++) begin
            sbq[i].delete();
            last_exp[i] = '0;
        end
    endtask

    task automatic idle();
        a_en = 1'b0; a_we = 1'b0; a_bank = 1'b0; a_addr = '0; a_din = '0;
        b_en = 1'b0; b_bank = 1'b0; b_addr = '0;
        c_a_en = 1'b0; c_a_we = 1'b0; c_a_bank = '0; c_a_addr = '0; c_a_din = '0;
        c_b_en = 1'b0; c_b_bank = '0; c_b_addr = '0;
    endtask

    // Releases reset and counts busy cycles while hammering both ports; nothing may be accepted.
    task automatic clear_window(input int exp01, input int exp2);
        int n0 = 0;
        int n1 = 0;
        int n2 = 0;
        rst = 1'b0;
        for (int t = 0; t < 24; t++) begin
            if (busy0) n0++;
            if (busy1) n1++;
            if (busy2) n2++;
            a_en = busy0; a_we = busy0; a_bank = 1'b0; a_addr = 4'd0; a_din = 16'sd77;
            b_en = busy0; b_bank = 1'b1; b_addr = 4'd5;
            c_a_en = busy2; c_a_we = busy2; c_a_bank = 2'd0; c_a_addr = 4'd0; c_a_din = 16'sd77;
            c_b_en = busy2; c_b_bank = 2'd2; c_b_addr = 4'd0;
            step();
        end
        idle();
        chk("u0 clear length", n0, exp01);
        chk("u1 clear length", n1, exp01);
        chk("u2 clear length", n2, exp2);
        chk("u0 ready", busy0, 0);
        chk("u1 ready", busy1, 0);
        chk("u2 ready", busy2, 0);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        cyc   = 0;
        rst   = 1'b1;
        idle();
        flush();

        //            ae we ab aa  din     be bb ba  old     new
        tab[0]  = mk(1, 1, 1, 5,  -7,     0, 0, 0,  0,      0);
        tab[1]  = mk(1, 1, 0, 0,  10,     1, 1, 5,  -7,     -7);
        tab[2]  = mk(1, 1, 0, 1,  20,     1, 0, 5,  0,      0);
        tab[3]  = mk(1, 1, 0, 2,  30,     1, 0, 0,  10,     10);
        tab[4]  = mk(1, 1, 0, 3,  4,      1, 0, 1,  20,     20);
        tab[5]  = mk(0, 0, 0, 0,  0,      1, 0, 2,  30,     30);
        tab[6]  = mk(1, 1, 0, 3,  99,     1, 0, 3,  4,      99);
        tab[7]  = mk(0, 0, 0, 0,  0,      1, 0, 3,  99,     99);
        tab[8]  = mk(1, 1, 1, 15, -32768, 1, 1, 15, 0,      -32768);
        tab[9]  = mk(0, 0, 0, 0,  0,      1, 1, 15, -32768, -32768);
        tab[10] = mk(0, 1, 1, 0,  55,     1, 1, 0,  0,      0);
        tab[11] = mk(1, 0, 1, 1,  66,     1, 1, 1,  0,      0);
        tab[12] = mk(0, 0, 0, 0,  0,      1, 1, 0,  0,      0);
        tab[13] = mk(0, 0, 0, 0,  0,      0, 0, 0,  0,      0);
        tab[14] = mk(1, 1, 1, 4,  123,    1, 0, 4,  0,      0);
        tab[15] = mk(0, 0, 0, 0,  0,      1, 1, 4,  123,    123);

        tab2[0]  = mk(1, 1, 2, 11, 500, 0, 0, 0,  0,   0);
        tab2[1]  = mk(1, 1, 0, 11, 9,   1, 2, 11, 500, 0);
        tab2[2]  = mk(1, 1, 0, 12, 111, 1, 3, 0,  0,   0);
        tab2[3]  = mk(1, 1, 3, 0,  222, 1, 0, 11, 9,   0);
        tab2[4]  = mk(1, 1, 1, 11, 8,   1, 3, 11, 0,   0);
        tab2[5]  = mk(0, 0, 0, 0,  0,   1, 0, 12, 0,   0);
        tab2[6]  = mk(0, 0, 0, 0,  0,   1, 1, 11, 8,   0);
        tab2[7]  = mk(0, 0, 0, 0,  0,   1, 0, 0,  0,   0);
        tab2[8]  = mk(0, 0, 0, 0,  0,   1, 3, 15, 0,   0);
        tab2[9]  = mk(0, 0, 0, 0,  0,   1, 2, 0,  0,   0);
        tab2[10] = mk(1, 1, 2, 15, 1,   1, 2, 15, 0,   0);
        tab2[11] = mk(0, 0, 0, 0,  0,   1, 2, 11, 500, 0);

        for (int i = 0; i < 3; i++) begin
            step();
            chk("u0 busy in reset", busy0, 1);
            chk("u1 busy in reset", busy1, 1);
            chk("u2 busy in reset", busy2, 1);
        end

        clear_window(16, 12);

        for (int b = 0; b < 2; b++) begin
            for (int a = 0; a < 16; a++) begin
                b_en = 1'b1; b_bank = b[0]; b_addr = a[3:0];
                push(0, 1, '0);
                push(1, 2, '0);
                step();
            end
        end
        idle();
        repeat (3) step();

        for (int i = 0; i < 16; i++) begin
            a_en = tab[i].a_en; a_we = tab[i].a_we; a_bank = tab[i].a_bank[0];
            a_addr = tab[i].a_addr; a_din = tab[i].a_din;
            b_en = tab[i].b_en; b_bank = tab[i].b_bank[0]; b_addr = tab[i].b_addr;
            if (tab[i].b_en) begin
                push(0, 1, tab[i].exp_old);
                push(1, 2, tab[i].exp_new);
            end
            step();
        end
        idle();
        repeat (3) step();

        for (int i = 0; i < 12; i++) begin
            c_a_en = tab2[i].a_en; c_a_we = tab2[i].a_we; c_a_bank = tab2[i].a_bank;
            c_a_addr = tab2[i].a_addr; c_a_din = tab2[i].a_din;
            c_b_en = tab2[i].b_en; c_b_bank = tab2[i].b_bank; c_b_addr = tab2[i].b_addr;
            if (tab2[i].b_en) push(2, 1, tab2[i].exp_old);
            step();
        end
        idle();
        repeat (2) step();

        // Reset while u1 still has a read in flight: it must vanish.
        b_en = 1'b1; b_bank = 1'b1; b_addr = 4'd5;
        push(0, 1, -16'sd7);
        push(1, 2, -16'sd7);
        step();
        idle();
        rst = 1'b1;
        flush();
        repeat (2) step();

        // Reset again at clear cycle 8.
        rst = 1'b0;
        for (int t = 0; t < 8; t++) begin
            step();
            chk("u0 busy mid-clear", busy0, 1);
        end
        rst = 1'b1;
        flush();
        repeat (2) step();
        chk("u1 busy in reset", busy1, 1);

        clear_window(16, 12);

        b_en = 1'b1; b_bank = 1'b0; b_addr = 4'd0;
        c_b_en = 1'b1; c_b_bank = 2'd0; c_b_addr = 4'd0;
        push(0, 1, '0); push(1, 2, '0); push(2, 1, '0);
        step();
        b_bank = 1'b1; b_addr = 4'd5;
        c_b_bank = 2'd2; c_b_addr = 4'd11;
        push(0, 1, '0); push(1, 2, '0); push(2, 1, '0);
        step();
        idle();
        repeat (3) step();

        chk("u0 scoreboard drained", sbq[0].size(), 0);
        chk("u1 scoreboard drained", sbq[1].size(), 0);
        chk("u2 scoreboard drained", sbq[2].size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
